// File: rtl/types_pkg.sv
// Shared types and constants for the command serializer: the byte type,
// the status code reported on a response timeout, and the FSM state encoding.
package types_pkg;

    typedef logic [7:0] byte_t;

    localparam byte_t RESP_TIMEOUT_CODE = 8'hFF;

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        SEND_OP      = 3'd1,
        SEND_PAYLOAD = 3'd2,
        WAIT_RESP    = 3'd3,
        REPORT       = 3'd4
    } cmd_ser_state_t;

endpackage

// File: rtl/command_serializer.sv
// Accepts one command (opcode + up to MAX_PAYLOAD_BYTES payload bytes), streams it
// out byte by byte, then optionally waits for a single response byte and reports it.
//
// Handshakes: every *_valid/*_ready pair transfers on a rising edge where both are
// high; a source keeps valid and data stable until that transfer happens.
module command_serializer
    import types_pkg::*;
#(
    parameter int MAX_PAYLOAD_BYTES = 48,
    parameter int TIMEOUT_CYCLES    = 1024,
    localparam int LEN_W            = $clog2(MAX_PAYLOAD_BYTES + 1)
) (
    input  logic                           clk,
    input  logic                           rst,

    input  logic                           cmd_s_valid,
    output logic                           cmd_s_ready,
    input  byte_t                          cmd_s_opcode,
    input  logic [MAX_PAYLOAD_BYTES*8-1:0] cmd_s_payload,
    input  logic [LEN_W-1:0]               cmd_s_length,
    input  logic                           cmd_s_noresp,

    output logic                           tx_m_valid,
    input  logic                           tx_m_ready,
    output byte_t                          tx_m_data,

    input  logic                           rx_s_valid,
    output logic                           rx_s_ready,
    input  byte_t                          rx_s_data,

    output logic                           status_m_valid,
    input  logic                           status_m_ready,
    output logic [7:0]                     status_m_data,
    output logic                           status_m_timeout,

    output logic                           busy,
    output cmd_ser_state_t                 dbg_state
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [LEN_W-1:0] MAX_LEN  = LEN_W'(MAX_PAYLOAD_BYTES);

    cmd_ser_state_t   state_q, state_d;
    byte_t            opcode_q, opcode_d;
    byte_t            payload_q [MAX_PAYLOAD_BYTES];
    byte_t            payload_d [MAX_PAYLOAD_BYTES];
    logic [LEN_W-1:0] len_q, len_d;
    logic             noresp_q, noresp_d;
    logic [LEN_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    byte_t            st_data_q, st_data_d;
    logic             st_timeout_q, st_timeout_d;

    logic           cmd_fire;
    logic           tx_fire;
    logic           rx_fire;
    cmd_ser_state_t post_send_state;

    // Every output is forced inactive while rst is high, including the cycle in
    // which reset is first sampled, so an abandoned frame never leaks a byte.
    assign cmd_s_ready      = !rst && (state_q == IDLE);
    assign tx_m_valid       = !rst && ((state_q == SEND_OP) || (state_q == SEND_PAYLOAD));
    assign rx_s_ready       = !rst && (state_q != REPORT);
    assign status_m_valid   = !rst && (state_q == REPORT);
    assign status_m_data    = rst ? 8'h00 : st_data_q;
    assign status_m_timeout = !rst && st_timeout_q;
    assign busy             = !rst && (state_q != IDLE);
    assign dbg_state        = state_q;

    assign cmd_fire = cmd_s_valid && cmd_s_ready;
    assign tx_fire  = tx_m_valid && tx_m_ready;
    assign rx_fire  = rx_s_valid && rx_s_ready;

    assign post_send_state = noresp_q ? IDLE : WAIT_RESP;

    always_comb begin
        tx_m_data = 8'h00;
        if (!rst) begin
            if (state_q == SEND_OP) begin
                tx_m_data = opcode_q;
            end else if (state_q == SEND_PAYLOAD) begin
                tx_m_data = payload_q[idx_q];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        opcode_d     = opcode_q;
        payload_d    = payload_q;
        len_d        = len_q;
        noresp_d     = noresp_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        st_data_d    = st_data_q;
        st_timeout_d = st_timeout_q;

        case (state_q)
            IDLE: begin
                if (cmd_fire) begin
                    opcode_d = cmd_s_opcode;
                    for (int i = 0; i < MAX_PAYLOAD_BYTES; i++) begin
                        payload_d[i] = cmd_s_payload[8*i +: 8];
                    end
                    len_d    = (cmd_s_length > MAX_LEN) ? MAX_LEN : cmd_s_length;
                    noresp_d = cmd_s_noresp;
                    idx_d    = '0;
                    cnt_d    = '0;
                    state_d  = SEND_OP;
                end
            end

            SEND_OP: begin
                if (tx_fire) begin
                    state_d = (len_q != '0) ? SEND_PAYLOAD : post_send_state;
                end
            end

            SEND_PAYLOAD: begin
                if (tx_fire) begin
                    if (idx_q == len_q - LEN_W'(1)) begin
                        state_d = post_send_state;
                    end else begin
                        idx_d = idx_q + LEN_W'(1);
                    end
                end
            end

            WAIT_RESP: begin
                // A response arriving on the last counted cycle beats the timeout.
                if (rx_fire) begin
                    st_data_d    = rx_s_data;
                    st_timeout_d = 1'b0;
                    state_d      = REPORT;
                end else if (cnt_q == CNT_LAST) begin
                    st_data_d    = RESP_TIMEOUT_CODE;
                    st_timeout_d = 1'b1;
                    state_d      = REPORT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            REPORT: begin
                if (status_m_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            opcode_q     <= '0;
            payload_q    <= '{default: '0};
            len_q        <= '0;
            noresp_q     <= 1'b0;
            idx_q        <= '0;
            cnt_q        <= '0;
            st_data_q    <= '0;
            st_timeout_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            opcode_q     <= opcode_d;
            payload_q    <= payload_d;
            len_q        <= len_d;
            noresp_q     <= noresp_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            st_data_q    <= st_data_d;
            st_timeout_q <= st_timeout_d;
        end
    end

endmodule

// File: tb/tb_command_serializer.sv
// Randomized and directed bench for command_serializer: a transaction-level model
// predicts the transmitted frame and the completion report for every command.
module tb_command_serializer;
  import types_pkg::*;

  localparam int MAXB   = 48;
  localparam int TOUT   = 16;
  localparam int LEN_W  = $clog2(MAXB + 1);
  localparam int BUDGET = 200;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic                  cmd_s_valid;
  logic                  cmd_s_ready;
  logic [7:0]            cmd_s_opcode;
  logic [MAXB*8-1:0]     cmd_s_payload;
  logic [LEN_W-1:0]      cmd_s_length;
  logic                  cmd_s_noresp;
  logic                  tx_m_valid;
  logic                  tx_m_ready;
  logic [7:0]            tx_m_data;
  logic                  rx_s_valid;
  logic                  rx_s_ready;
  logic [7:0]            rx_s_data;
  logic                  status_m_valid;
  logic                  status_m_ready;
  logic [7:0]            status_m_data;
  logic                  status_m_timeout;
  logic                  busy;
  cmd_ser_state_t        dbg_state;

  command_serializer #(.MAX_PAYLOAD_BYTES(MAXB), .TIMEOUT_CYCLES(TOUT)) dut (
    .clk              (clk),
    .rst              (rst),
    .cmd_s_valid      (cmd_s_valid),
    .cmd_s_ready      (cmd_s_ready),
    .cmd_s_opcode     (cmd_s_opcode),
    .cmd_s_payload    (cmd_s_payload),
    .cmd_s_length     (cmd_s_length),
    .cmd_s_noresp     (cmd_s_noresp),
    .tx_m_valid       (tx_m_valid),
    .tx_m_ready       (tx_m_ready),
    .tx_m_data        (tx_m_data),
    .rx_s_valid       (rx_s_valid),
    .rx_s_ready       (rx_s_ready),
    .rx_s_data        (rx_s_data),
    .status_m_valid   (status_m_valid),
    .status_m_ready   (status_m_ready),
    .status_m_data    (status_m_data),
    .status_m_timeout (status_m_timeout),
    .busy             (busy),
    .dbg_state        (dbg_state)
  );

  // scoreboard
  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // driver: one full command. mode 0 = ready held high, 1 = toggling, 2 = random.
  // rx_delay = WAIT_RESP cycle on which the response is offered, -1 for none.
  task automatic run_cmd(input logic [7:0] op, input logic [MAXB*8-1:0] pl, input int len,
                         input bit noresp, input int mode, input int rx_delay,
                         input logic [7:0] rx_byte);
    int n_exp, c, got, wait_n, exp_w, hold;
    bit prev_stall, r;
    logic [7:0] prev_data, exp_byte;

    exp_q.delete();
    exp_q.push_back(op);
    for (int i = 0; i < ((len > MAXB) ? MAXB : len); i++) exp_q.push_back(pl[8*i +: 8]);
    n_exp = exp_q.size();

    wait_n = 0;
    @(negedge clk);
    while (!cmd_s_ready && wait_n < BUDGET) begin
      @(negedge clk);
      wait_n++;
    end
    check_eq("cmd_ready_idle", cmd_s_ready, 1);
    cmd_s_valid   = 1'b1;
    cmd_s_opcode  = op;
    cmd_s_payload = pl;
    cmd_s_length  = LEN_W'(len);
    cmd_s_noresp  = noresp;
    @(posedge clk);

    c = 0; got = 0; prev_stall = 1'b0; prev_data = 8'h00;
    while (got < n_exp && c < 4 * n_exp + BUDGET) begin
      @(negedge clk);
      cmd_s_valid = 1'b0;
      check_eq("busy_tx", busy, 1);
      check_eq("cmd_ready_tx", cmd_s_ready, 0);
      if (prev_stall) begin
        check_eq("tx_hold_valid", tx_m_valid, 1);
        check_eq("tx_hold_data", tx_m_data, prev_data);
      end
      case (mode)
        0:       r = 1'b1;
        1:       r = ((c % 2) == 0);
        default: r = 1'($urandom_range(0, 1));
      endcase
      tx_m_ready = r;
      rx_s_valid = ($urandom_range(0, 3) == 0);
      rx_s_data  = 8'h5A;
      if (rx_s_valid) check_eq("rx_ready_drain", rx_s_ready, 1);
      if (tx_m_valid && r) begin
        exp_byte = exp_q.pop_front();
        check_eq("tx_byte", tx_m_data, exp_byte);
        if (mode == 0) check_eq("tx_no_bubble", c, got);
        got++;
      end else if (mode == 0) begin
        check_eq("tx_valid_stream", tx_m_valid, 1);
      end
      prev_stall = tx_m_valid && !r;
      prev_data  = tx_m_data;
      c++;
    end
    check_eq("tx_frame_complete", got, n_exp);

    @(negedge clk);
    tx_m_ready = 1'b0;
    rx_s_valid = 1'b0;
    check_eq("tx_valid_after_frame", tx_m_valid, 0);
    if (noresp) begin
      check_eq("noresp_cmd_ready", cmd_s_ready, 1);
      check_eq("noresp_no_report", status_m_valid, 0);
      check_eq("noresp_idle", busy, 0);
      return;
    end

    exp_w = (rx_delay >= 0 && rx_delay < TOUT) ? rx_delay + 1 : TOUT;
    for (int w = 0; w <= exp_w; w++) begin
      if (w > 0) @(negedge clk);
      rx_s_valid = (w == rx_delay);
      rx_s_data  = rx_byte;
      if (w == rx_delay) check_eq("rx_ready_wait", rx_s_ready, 1);
      check_eq("report_timing", status_m_valid, (w == exp_w));
    end
    rx_s_valid = 1'b0;
    check_eq("status_data", status_m_data, (exp_w == TOUT && rx_delay != TOUT - 1) ? 8'hFF : rx_byte);
    check_eq("status_timeout", status_m_timeout, (exp_w == TOUT && rx_delay != TOUT - 1));
    check_eq("rx_ready_report", rx_s_ready, 0);

    prev_data = status_m_data;
    r         = status_m_timeout;
    hold      = $urandom_range(0, 3);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check_eq("status_hold_valid", status_m_valid, 1);
      check_eq("status_hold_data", status_m_data, prev_data);
      check_eq("status_hold_timeout", status_m_timeout, r);
    end
    status_m_ready = 1'b1;
    @(negedge clk);
    status_m_ready = 1'b0;
    check_eq("status_done", status_m_valid, 0);
    check_eq("cmd_ready_after_report", cmd_s_ready, 1);
  endtask

  task automatic reset_midframe();
    int got, c;
    @(negedge clk);
    cmd_s_valid   = 1'b1;
    cmd_s_opcode  = 8'h42;
    cmd_s_payload = '0;
    cmd_s_payload[31:0] = 32'h44332211;
    cmd_s_length  = LEN_W'(4);
    cmd_s_noresp  = 1'b0;
    @(posedge clk);
    got = 0; c = 0;
    while (got < 2 && c < BUDGET) begin
      @(negedge clk);
      cmd_s_valid = 1'b0;
      tx_m_ready  = 1'b1;
      if (tx_m_valid) got++;
      c++;
    end
    check_eq("midframe_two_bytes", got, 2);
    @(negedge clk);
    rst        = 1'b1;
    tx_m_ready = 1'b0;
    @(negedge clk);
    check_eq("midrst_tx_valid", tx_m_valid, 0);
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_status_valid", status_m_valid, 0);
    check_eq("midrst_tx_data", tx_m_data, 0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("midrst_cmd_ready", cmd_s_ready, 1);
    check_eq("midrst_no_report", status_m_valid, 0);
  endtask

  function automatic logic [MAXB*8-1:0] rand_payload();
    logic [MAXB*8-1:0] p;
    for (int i = 0; i < MAXB; i++) p[8*i +: 8] = 8'($urandom_range(0, 255));
    return p;
  endfunction

  initial begin
    logic [MAXB*8-1:0] pl;
    int len, dly;

    rst = 1'b1;
    cmd_s_valid = 1'b0; cmd_s_opcode = '0; cmd_s_payload = '0; cmd_s_length = '0;
    cmd_s_noresp = 1'b0; tx_m_ready = 1'b0; rx_s_valid = 1'b0; rx_s_data = '0;
    status_m_ready = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_cmd_ready", cmd_s_ready, 0);
    check_eq("rst_tx_valid", tx_m_valid, 0);
    check_eq("rst_status_valid", status_m_valid, 0);
    check_eq("rst_status_timeout", status_m_timeout, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_rx_ready", rx_s_ready, 0);
    check_eq("rst_tx_data", tx_m_data, 0);
    check_eq("rst_status_data", status_m_data, 0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("cmd_ready_after_rst", cmd_s_ready, 1);

    pl = '0;
    pl[23:0] = 24'hCCBBAA;
    run_cmd(8'h01, pl, 3, 1'b0, 0, 2, 8'h00);
    run_cmd(8'h01, pl, 3, 1'b0, 1, 0, 8'h00);
    run_cmd(8'h01, pl, 3, 1'b0, 0, -1, 8'h00);
    run_cmd(8'h01, pl, 3, 1'b0, 0, TOUT - 1, 8'h3C);
    run_cmd(8'h7F, pl, 0, 1'b1, 0, -1, 8'h00);
    reset_midframe();
    run_cmd(8'h99, pl, 3, 1'b0, 0, 1, 8'hA5);
    run_cmd(8'hE3, rand_payload(), 63, 1'b1, 0, -1, 8'h00);
    run_cmd(8'h10, rand_payload(), MAXB, 1'b0, 2, 5, 8'hFF);

    for (int t = 0; t < 30; t++) begin
      len = $urandom_range(0, 63);
      dly = int'($urandom_range(0, TOUT)) - 1;
      run_cmd(8'($urandom_range(0, 255)), rand_payload(), len, 1'($urandom_range(0, 1)),
              $urandom_range(0, 2), dly, 8'($urandom_range(0, 255)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
